// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state encoding and small decode helpers.
package ahb_pkg;

  localparam int unsigned AHB_DW    = 32;
  localparam int unsigned AHB_LANES = AHB_DW / 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DATA = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase attributes held for the data phase
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [1:0] addr_lo;
  } ahb_aphase_t;

  // Little-endian byte-lane enables for an aligned transfer
  function automatic logic [AHB_LANES-1:0] byte_lanes(input logic [2:0] size,
                                                      input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: byte_lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_reg_bank.sv
// Register bank: byte-enable writes, combinational read mux, per-register write strobe.
module ahb_reg_bank
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned IW       = $clog2(NUM_REGS)
) (
  input  logic                   HCLK,
  input  logic                   RESET,
  input  logic                   we,
  input  logic [IW-1:0]          wr_idx,
  input  logic [DW/8-1:0]        be,
  input  logic [DW-1:0]          wdata,
  input  logic [IW-1:0]          rd_idx,
  output logic [DW-1:0]          rd_data_c,
  output logic [NUM_REGS*DW-1:0] reg_q,
  output logic [NUM_REGS-1:0]    wr_stb
);

  logic [DW-1:0] regs_q [NUM_REGS];

  // Lanes without an enable keep their previous contents
  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      wr_stb <= '0;
    end else begin
      wr_stb <= '0;
      if (we) begin
        wr_stb[wr_idx] <= 1'b1;
        for (int b = 0; b < int'(DW / 8); b++) begin
          if (be[b]) regs_q[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_c = regs_q[rd_idx];

  for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_flat
    assign reg_q[gi*DW +: DW] = regs_q[gi];
  end

endmodule

// File: rtl/ahb_slave_regs.sv
// AHB-Lite register slave: protocol FSM, decode/error checks, optional wait states.
// Define AHB_SLV_WAIT_EN to build the WAIT state and its 4-bit wait counter.
module ahb_slave_regs
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                           HCLK,
  input  logic                           RESET,
  input  logic                           HSEL,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [2:0]                     HBURST,
  input  logic [DATA_WIDTH-1:0]          HWDATA,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic                           HRESP,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
  output logic [NUM_REGS-1:0]            WR_STB
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  if (DATA_WIDTH != 32 || NUM_REGS < 2 || NUM_REGS > 64 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0 || WAIT_STATES > 15 || ADDR_WIDTH <= 12) begin : g_bad_params
    $error("ahb_slave_regs: unsupported parameter set");
  end

  slv_state_e             state_q, state_d;
  logic                   accept_c, illegal_c, commit_c;
  logic                   hreadyout_d, hresp_d;
  logic [IW-1:0]          idx_q;
  ahb_aphase_t            aph_q;
  logic [AHB_LANES-1:0]   be_c;
  logic [DATA_WIDTH-1:0]  rd_data_c;
  logic                   unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[ADDR_WIDTH-1:12]};

  // New address phases are only sampled when the previous data phase is ending
  assign accept_c = HSEL & HREADY & HTRANS[1] &
                    ((state_q == SLV_IDLE) | (state_q == SLV_DATA) | (state_q == SLV_ERR2));

  assign illegal_c = (HSIZE > HSIZE_WORD) ||
                     ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) ||
                     ((HADDR[11:0] >> (IW + 2)) != 12'd0);

  assign commit_c = (state_q == SLV_DATA) && aph_q.write;
  assign be_c     = byte_lanes(aph_q.size, aph_q.addr_lo);

`ifdef AHB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) wait_cnt_q <= 4'd0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= SLV_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      state_q   <= state_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
    end
  end

  // Address-phase capture
  always_ff @(posedge HCLK or negedge RESET) begin
    if (!RESET) begin
      idx_q <= '0;
      aph_q <= '0;
    end else if (accept_c) begin
      idx_q <= HADDR[IW+1:2];
      aph_q <= '{write: HWRITE, size: HSIZE, addr_lo: HADDR[1:0]};
    end
  end

  // Next state; HREADYOUT/HRESP follow the state being entered
  always_comb begin
    state_d     = state_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
`ifdef AHB_SLV_WAIT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      SLV_IDLE, SLV_DATA, SLV_ERR2: begin
        if (!accept_c) begin
          state_d = SLV_IDLE;
        end else if (illegal_c) begin
          state_d = SLV_ERR1;
        end else begin
`ifdef AHB_SLV_WAIT_EN
          wait_cnt_d = WAIT_LOAD;
          state_d    = (WAIT_LOAD != 4'd0) ? SLV_WAIT : SLV_DATA;
`else
          state_d = SLV_DATA;
`endif
        end
      end
`ifdef AHB_SLV_WAIT_EN
      SLV_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) state_d = SLV_DATA;
      end
`endif
      SLV_ERR1: state_d = SLV_ERR2;
      default:  state_d = SLV_IDLE;
    endcase

    case (state_d)
      SLV_WAIT: hreadyout_d = 1'b0;
      SLV_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      SLV_ERR2: hresp_d = HRESP_ERROR;
      default: ;
    endcase
  end

  assign HRDATA = ((state_q == SLV_DATA) && !aph_q.write) ? rd_data_c : '0;

  ahb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .DW       (DATA_WIDTH),
    .IW       (IW)
  ) u_bank (
    .HCLK      (HCLK),
    .RESET     (RESET),
    .we        (commit_c),
    .wr_idx    (idx_q),
    .be        (be_c),
    .wdata     (HWDATA),
    .rd_idx    (idx_q),
    .rd_data_c (rd_data_c),
    .reg_q     (REG_Q),
    .wr_stb    (WR_STB)
  );

endmodule

// File: tb/tb_ahb_slave_regs.sv
// Directed bench for ahb_slave_regs; wait-state scenarios run when AHB_SLV_WAIT_EN is defined.
module tb_ahb_slave_regs;
  import ahb_pkg::*;

  localparam int unsigned NR = 8;

  logic             HCLK = 1'b0;
  logic             RESET = 1'b0;
  logic             HSEL = 1'b0;
  logic [31:0]      HADDR = '0;
  logic [1:0]       HTRANS = HTRANS_IDLE;
  logic             HWRITE = 1'b0;
  logic [2:0]       HSIZE = HSIZE_WORD;
  logic [2:0]       HBURST = HBURST_SINGLE;
  logic [31:0]      HWDATA = '0;
  logic             HREADY;
  logic             HREADYOUT, HRESP;
  logic [31:0]      HRDATA;
  logic [NR*32-1:0] REG_Q;
  logic [NR-1:0]    WR_STB;
  logic             hready_en = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0]      bd [4] = '{32'h0102_0304, 32'h1111_2222, 32'hA5A5_5A5A, 32'h8000_0001};
  logic [NR*32-1:0] exp_q;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT & hready_en;

  ahb_slave_regs #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .NUM_REGS (NR), .WAIT_STATES (2)
  ) dut (
    .HCLK (HCLK), .RESET (RESET), .HSEL (HSEL), .HADDR (HADDR), .HTRANS (HTRANS),
    .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST), .HWDATA (HWDATA),
    .HREADY (HREADY), .HREADYOUT (HREADYOUT), .HRESP (HRESP), .HRDATA (HRDATA),
    .REG_Q (REG_Q), .WR_STB (WR_STB)
  );

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [1:0] tr);
    HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = tr;
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    drive_idle();
    repeat (2) cyc();
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout: got %b exp 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp: got %b exp 0", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h exp 0", HRDATA); end
    checks++; if (WR_STB !== 8'h00) begin errors++; $display("FAIL rst_wr_stb: got %h exp 00", WR_STB); end
    checks++; if (REG_Q !== '0) begin errors++; $display("FAIL rst_reg_q: got %h exp 0", REG_Q); end
    RESET = 1'b1;
    cyc();
  endtask

  task automatic test_word_rw();
    drive_addr(32'h004, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL wr_zero_wait: got %b exp 10", {HREADYOUT, HRESP}); end
    checks++; if (WR_STB !== 8'h00) begin errors++; $display("FAIL wr_stb_early: got %h exp 00", WR_STB); end
    HWDATA = 32'hDEAD_BEEF;
    drive_addr(32'h004, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if (REG_Q[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_reg1: got %h exp deadbeef", REG_Q[63:32]); end
    checks++; if (WR_STB !== 8'h02) begin errors++; $display("FAIL wr_stb: got %h exp 02", WR_STB); end
    checks++; if (HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr: got %h exp deadbeef", HRDATA); end
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL rd_okay: got %b exp 10", {HREADYOUT, HRESP}); end
    drive_idle();
    cyc();
    checks++; if (WR_STB !== 8'h00) begin errors++; $display("FAIL wr_stb_one_cycle: got %h exp 00", WR_STB); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rd_idle_zero: got %h exp 0", HRDATA); end
  endtask

  task automatic test_byte_half();
    drive_addr(32'h006, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ);
    cyc();
    HWDATA = 32'h55AA_5555;
    drive_addr(32'h004, 1'b1, HSIZE_HALF, HTRANS_NONSEQ);
    cyc();
    checks++; if (REG_Q[63:32] !== 32'hDEAA_BEEF) begin errors++; $display("FAIL byte_lane2: got %h exp deaabeef", REG_Q[63:32]); end
    checks++; if (WR_STB !== 8'h02) begin errors++; $display("FAIL byte_stb: got %h exp 02", WR_STB); end
    HWDATA = 32'h7777_1234;
    drive_addr(32'h00E, 1'b1, HSIZE_HALF, HTRANS_NONSEQ);
    cyc();
    checks++; if (REG_Q[63:32] !== 32'hDEAA_1234) begin errors++; $display("FAIL half_low: got %h exp deaa1234", REG_Q[63:32]); end
    HWDATA = 32'hCAFE_9999;
    drive_idle();
    cyc();
    checks++; if (REG_Q[127:96] !== 32'hCAFE_0000) begin errors++; $display("FAIL half_high: got %h exp cafe0000", REG_Q[127:96]); end
    checks++; if (WR_STB !== 8'h08) begin errors++; $display("FAIL half_high_stb: got %h exp 08", WR_STB); end
  endtask

  task automatic test_burst();
    HBURST = HBURST_INCR4;
    drive_addr(32'h000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL burst_beat0: got %b exp 10", {HREADYOUT, HRESP}); end
    HWDATA = bd[0];
    drive_addr(32'h004, 1'b1, HSIZE_WORD, HTRANS_SEQ);
    cyc();
    checks++; if ({HREADYOUT, HRESP, WR_STB} !== {2'b10, 8'h01}) begin errors++; $display("FAIL burst_beat1: got %b/%h exp 10/01", {HREADYOUT, HRESP}, WR_STB); end
    HWDATA = bd[1];
    drive_addr(32'h008, 1'b1, HSIZE_WORD, HTRANS_SEQ);
    cyc();
    checks++; if ({HREADYOUT, HRESP, WR_STB} !== {2'b10, 8'h02}) begin errors++; $display("FAIL burst_beat2: got %b/%h exp 10/02", {HREADYOUT, HRESP}, WR_STB); end
    HWDATA = bd[2];
    drive_addr(32'h00C, 1'b1, HSIZE_WORD, HTRANS_BUSY);
    cyc();
    checks++; if (WR_STB !== 8'h04) begin errors++; $display("FAIL burst_beat2_stb: got %h exp 04", WR_STB); end
    drive_addr(32'h00C, 1'b1, HSIZE_WORD, HTRANS_SEQ);
    cyc();
    checks++; if (WR_STB !== 8'h00) begin errors++; $display("FAIL burst_busy_no_data: got %h exp 00", WR_STB); end
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL burst_beat3: got %b exp 10", {HREADYOUT, HRESP}); end
    HWDATA = bd[3];
    drive_idle();
    HBURST = HBURST_SINGLE;
    cyc();
    checks++; if (WR_STB !== 8'h08) begin errors++; $display("FAIL burst_beat3_stb: got %h exp 08", WR_STB); end
    checks++; if (REG_Q[127:0] !== {bd[3], bd[2], bd[1], bd[0]}) begin errors++; $display("FAIL burst_regs: got %h exp %h", REG_Q[127:0], {bd[3], bd[2], bd[1], bd[0]}); end
  endtask

  task automatic test_hready_low();
    hready_en = 1'b0;
    HWDATA = 32'hBAD0_BAD0;
    drive_addr(32'h010, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL hrdy_low_idle: got %b exp 1", HREADYOUT); end
    hready_en = 1'b1;
    cyc();
    checks++; if (WR_STB !== 8'h00) begin errors++; $display("FAIL hrdy_low_no_accept: got %h exp 00", WR_STB); end
    HWDATA = 32'h0000_C0DE;
    drive_idle();
    cyc();
    checks++; if (REG_Q[159:128] !== 32'h0000_C0DE) begin errors++; $display("FAIL hrdy_represent: got %h exp 0000c0de", REG_Q[159:128]); end
    checks++; if (WR_STB !== 8'h10) begin errors++; $display("FAIL hrdy_represent_stb: got %h exp 10", WR_STB); end
  endtask

  task automatic test_error();
    logic [31:0] ea [5] = '{32'h002, 32'h020, 32'h001, 32'h000, 32'h804};
    logic        ew [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  es [5] = '{HSIZE_WORD, HSIZE_WORD, HSIZE_HALF, 3'b011, HSIZE_BYTE};
    exp_q = '0;
    exp_q[159:0] = {32'h0000_C0DE, bd[3], bd[2], bd[1], bd[0]};
    for (int i = 0; i < 5; i++) begin
      drive_addr(ea[i], ew[i], es[i], HTRANS_NONSEQ);
      cyc();
      checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin errors++; $display("FAIL err1[%0d]: got %b exp 01", i, {HREADYOUT, HRESP}); end
      HWDATA = 32'hFFFF_FFFF;
      drive_idle();
      cyc();
      checks++; if ({HREADYOUT, HRESP, HRDATA} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err2[%0d]: got %b/%h exp 11/0", i, {HREADYOUT, HRESP}, HRDATA); end
      cyc();
      checks++; if ({HREADYOUT, HRESP, WR_STB} !== {2'b10, 8'h00}) begin errors++; $display("FAIL err_cancel[%0d]: got %b/%h exp 10/00", i, {HREADYOUT, HRESP}, WR_STB); end
      checks++; if (REG_Q !== exp_q) begin errors++; $display("FAIL err_no_write[%0d]: got %h exp %h", i, REG_Q, exp_q); end
    end
  endtask

  task automatic test_back_to_back_err();
    drive_addr(32'h020, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    drive_idle();
    cyc();
    checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin errors++; $display("FAIL b2b_err2: got %b exp 11", {HREADYOUT, HRESP}); end
    drive_addr(32'h014, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL b2b_data: got %b exp 10", {HREADYOUT, HRESP}); end
    HWDATA = 32'h5555_AAAA;
    drive_idle();
    cyc();
    checks++; if (REG_Q[191:160] !== 32'h5555_AAAA) begin errors++; $display("FAIL b2b_reg5: got %h exp 5555aaaa", REG_Q[191:160]); end
    checks++; if (WR_STB !== 8'h20) begin errors++; $display("FAIL b2b_stb: got %h exp 20", WR_STB); end
  endtask

  task automatic test_reset_mid();
    drive_addr(32'h040, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin errors++; $display("FAIL rmid_err1: got %b exp 01", {HREADYOUT, HRESP}); end
    drive_idle();
    #2 RESET = 1'b0;
    #1;
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL rmid_outputs: got %b exp 10", {HREADYOUT, HRESP}); end
    checks++; if (REG_Q !== '0) begin errors++; $display("FAIL rmid_regs: got %h exp 0", REG_Q); end
    cyc();
    RESET = 1'b1;
    cyc();
    checks++; if ({HREADYOUT, HRESP, WR_STB} !== {2'b10, 8'h00}) begin errors++; $display("FAIL rmid_after: got %b/%h exp 10/00", {HREADYOUT, HRESP}, WR_STB); end
  endtask

`ifdef AHB_SLV_WAIT_EN
  task automatic test_wait();
    drive_addr(32'h008, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL wwr_wait1: got %b exp 0", HREADYOUT); end
    HWDATA = 32'h0BAD_F00D;
    drive_idle();
    cyc();
    checks++; if ({HREADYOUT, WR_STB} !== {1'b0, 8'h00}) begin errors++; $display("FAIL wwr_wait2: got %b/%h exp 0/00", HREADYOUT, WR_STB); end
    cyc();
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL wwr_data: got %b exp 10", {HREADYOUT, HRESP}); end
    cyc();
    checks++; if ({REG_Q[95:64], WR_STB} !== {32'h0BAD_F00D, 8'h04}) begin errors++; $display("FAIL wwr_commit: got %h/%h exp 0badf00d/04", REG_Q[95:64], WR_STB); end
    drive_addr(32'h008, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if ({HREADYOUT, HRDATA} !== {1'b0, 32'h0}) begin errors++; $display("FAIL wrd_wait1: got %b/%h exp 0/0", HREADYOUT, HRDATA); end
    drive_idle();
    cyc();
    checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL wrd_wait2: got %b exp 0", HREADYOUT); end
    cyc();
    checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL wrd_data: got %b/%h exp 1/0badf00d", HREADYOUT, HRDATA); end
    cyc();
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL wrd_after: got %h exp 0", HRDATA); end
  endtask

  task automatic test_wait_reset();
    drive_addr(32'h00C, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    cyc();
    checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL wrst_wait: got %b exp 0", HREADYOUT); end
    HWDATA = 32'hFEED_FACE;
    drive_idle();
    #2 RESET = 1'b0;
    #1;
    checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL wrst_outputs: got %b exp 10", {HREADYOUT, HRESP}); end
    repeat (2) cyc();
    RESET = 1'b1;
    repeat (3) cyc();
    checks++; if (REG_Q !== '0) begin errors++; $display("FAIL wrst_discard: got %h exp 0", REG_Q); end
    checks++; if (WR_STB !== 8'h00) begin errors++; $display("FAIL wrst_stb: got %h exp 00", WR_STB); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef AHB_SLV_WAIT_EN
    test_wait();
    test_wait_reset();
`else
    test_word_rw();
    test_byte_half();
    test_burst();
    test_hready_low();
    test_error();
    test_back_to_back_err();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_regs.md
# ahb_slave_regs

AHB-Lite slave exposing a bank of NUM_REGS 32-bit control/status registers to the AHB master. Accepts SINGLE and INCR transfers of byte, halfword or word size, with little-endian byte-lane writes. Issues the two-cycle ERROR response for illegal accesses and can optionally insert wait states. It is the responder end of the bus that the SSP/CRC datapath is configured through.

## Interface
- DATA_WIDTH, 32, data bus width; fixed at 32.
- ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 8, number of 32-bit registers; power of 2, range 2..64.
- WAIT_STATES, 0, wait cycles per OKAY transfer; range 0..15; used only with AHB_SLV_WAIT_EN.
- HCLK  in  1  bus clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  ADDR_WIDTH  transfer address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; all others illegal.
- HBURST  in  3  informational only; decode does not depend on it.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; qualifies the address phase.
- HREADYOUT  out  1  slave ready; 0 extends the data phase.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- REG_Q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i is at bits [32i+31:32i].
- WR_STB  out  NUM_REGS  one-cycle pulse per register on write commit.

## Operation
- **Address phase accept:** HSEL & HREADY & HTRANS[1]. On accept, the block captures the register index HADDR[IW+1:2] (IW = log2 NUM_REGS), HADDR[1:0], HWRITE and HSIZE.
- **BUSY/IDLE, or HSEL=0:** no action. If no data phase is pending, the block returns a zero-wait OKAY.
- **Illegal access**, any of the following, gets the ERROR response and makes no register change:
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0] != 0;
  - HADDR[11:IW+2] != 0, i.e. outside the bank within the 4 KB window.
- **States:**
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0.
  - DATA: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- **Transitions:**
  - accept legal → WAIT if the wait count > 0, else DATA.
  - accept illegal → ERR1.
  - WAIT → DATA once the count expires.
  - ERR1 → ERR2 always.
  - DATA or ERR2 → re-evaluates accept in the same cycle (pipelined back-to-back), else IDLE.
- **Write commit:**
  - Occurs at the clock edge ending DATA.
  - Byte lanes: byte → lane HADDR[1:0]; halfword → lanes {HADDR[1],0}+{0,1}; word → all 4 lanes.
  - Untouched lanes keep their value.
  - WR_STB[idx] is high for exactly the cycle after commit.
- **Read:** HRDATA = register[idx_q] while in DATA for a read, else 0. A read immediately after a write to the same register returns the new value.
- **ERR2 cancel:** if the master drives IDLE in ERR2, nothing further happens.

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, WR_STB=0;
  - all registers 0, so REG_Q=0;
  - state IDLE, wait counter 0.
- Zero-wait legal transfer: address at edge N, data phase completes at edge N+1. Back-to-back transfers sustain 1 transfer/cycle.
- With waits: data phase lasts WAIT_STATES+1 cycles; the counter reloads on every accept.
- ERROR: exactly 2 data-phase cycles. HRESP=1 in both; HREADYOUT is 0 then 1.
- HREADY=0 with HTRANS valid: no accept; the transfer is re-presented later.
- Reset asserted mid-transfer: an uncommitted write is discarded and outputs go to reset values immediately.

## Configuration
- AHB_SLV_WAIT_EN:
  - Defined: the WAIT state and a 4-bit counter are built, and every legal transfer gets WAIT_STATES wait cycles.
  - Undefined: the WAIT state is not compiled, WAIT_STATES is ignored, and all OKAY transfers are zero-wait.

## Structure
- Shared package ahb_pkg:
  - HTRANS, HSIZE and HBURST encodings, already used by the master;
  - slave state encoding;
  - HRESP_OKAY/HRESP_ERROR constants.
- Sub-module ahb_reg_bank: NUM_REGS × 32-bit registers with 4-bit byte-enable write, write index, read index mux, and WR_STB generation.
- Top level: protocol FSM, decode and error checks, wait counter.

## Test plan
- Reset, then word write of 0xDEADBEEF to 0x004 → REG_Q[63:32]=0xDEADBEEF, WR_STB=0000_0010 for 1 cycle, 0 waits; word read of 0x004 returns 0xDEADBEEF.
- Byte write 0xAA to 0x006, then halfword write 0x1234 to 0x004 → reg1 = 0xDEAA1234 (from 0xDEADBEEF).
- Word write to 0x002 → 2-cycle ERROR (HREADYOUT 0,1; HRESP 1,1), reg0 unchanged. Access to 0x020 with NUM_REGS=8 → ERROR.
- INCR burst of 4 word writes 0x000–0x00C (NONSEQ,SEQ,SEQ,SEQ) → 4 consecutive OKAY cycles, regs 0–3 loaded; a BUSY inserted mid-burst inserts no data phase.
- AHB_SLV_WAIT_EN with WAIT_STATES=2: read 0x008 → HREADYOUT low 2 cycles, data on 3rd; RESET pulled during a waited write → reg unchanged, HREADYOUT=1.
